// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, parity, stop.
// Optional odd-parity check enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_receiver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data,
    output logic [7:0] code,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [DATA_W-1:0]   shift, shift_next;
    logic                par, par_next;
    logic [DATA_W-1:0]   code_next;
    logic                done_next;
    logic                frame_ok_c;

    // All state advances on the falling PS/2 clock edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
            par   <= 1'b0;
            code  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shift <= shift_next;
            par   <= par_next;
            code  <= code_next;
            done  <= done_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!data) state_next = DATA;
            DATA:    if (cnt == CNT_W'(DATA_W - 1)) state_next = PARITY;
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok_c = data && ((^shift) ^ par);
`else
    assign frame_ok_c = data;
`endif

    // Datapath and output next values.
    always_comb begin
        cnt_next   = cnt;
        shift_next = shift;
        par_next   = par;
        code_next  = code;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (!data) cnt_next = '0;
            end
            DATA: begin
                shift_next[cnt] = data;
                cnt_next        = cnt + CNT_W'(1);
            end
            PARITY: begin
                par_next = data;
            end
            STOP: begin
                if (frame_ok_c) begin
                    code_next = shift;
                    done_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: frames are driven on the rising edge,
// expected (code, edge index) pushed on valid frames and matched against done pulses.
module tb_ps2_frame_receiver;

    logic       clk;
    logic       rst_n;
    logic       data;
    logic [7:0] code;
    logic       done;

    typedef struct {
        logic [7:0] code;
        int         edge_idx;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         edge_cnt = 0;
    logic [7:0] last_code = 8'h00;
    logic       prev_done = 1'b0;

    ps2_frame_receiver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .code  (code),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(posedge clk) begin
        if (rst_n && done) begin
            check("done_width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("code", 32'(code), 32'(e.code));
                check("latency_edge", 32'(edge_cnt), 32'(e.edge_idx));
            end
        end
        prev_done <= done;
    end

    // Drive one 11-bit frame; each bit is set up on a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        logic [10:0] bits;
        logic        ok;
        bits = {s, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            data = bits[i];
        end
`ifdef PS2_PARITY_CHECK_EN
        ok = s && ((^b) ^ p);
`else
        ok = s;
`endif
        if (ok) begin
            exp_t e;
            e.code     = b;
            e.edge_idx = edge_cnt + 1;
            exp_q.push_back(e);
            last_code = b;
        end
    endtask

    // Return line to idle and confirm code holds the last accepted byte.
    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            data = 1'b1;
        end
        #1;
        check(tag, 32'(code), 32'(last_code));
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        data  = 1'b0;
        // Reset held with clock running and data low: nothing may be accepted.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("rst_code", 32'(code), 32'h00);
            check("rst_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        data  = 1'b1;
        rst_n = 1'b1;
        idle_check("idle_after_rst", 2);

        // Valid 0xAA.
        send_frame(8'hAA, 1'b1, 1'b1);
        idle_check("hold_aa", 3);

        // 0xAA with bad parity.
        send_frame(8'hAA, 1'b0, 1'b1);
        idle_check("parity_err", 3);

        // Stop-bit error.
        send_frame(8'h1C, 1'b0, 1'b0);
        idle_check("stop_err", 3);

        // Back-to-back frames with no idle gap.
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        idle_check("b2b", 3);

        // Reset after start bit plus five data bits.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            data = (i == 0) ? 1'b0 : 1'b1;
        end
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        last_code = 8'h00;
        check("midrst_code", 32'(code), 32'h00);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        data  = 1'b1;
        rst_n = 1'b1;
        idle_check("after_midrst", 2);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle_check("hold_5a", 3);

        // Random valid frames with correct odd parity.
        for (int k = 0; k < 6; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_frame(b, ~(^b), 1'b1);
        end
        idle_check("rand_tail", 3);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("pending", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
